// File: rtl/frame_sequencer.sv
// Raster frame sequencer: walks columns, blanking ticks and rows on each
// accepted rising edge of the divided clock, framing with start/done pulses.
module frame_sequencer #(
    parameter int COLS   = 64,
    parameter int ROWS   = 32,
    parameter int HBLANK = 4
) (
    input  logic                    CLKIN,
    input  logic                    Reset,
    input  logic                    SYN1,
    input  logic                    CLK_DIV,
    input  logic                    Enable,
    output logic                    Tick,
    output logic                    Frame_start,
    output logic                    Line_valid,
    output logic [$clog2(COLS)-1:0] Col_addr,
    output logic [$clog2(ROWS)-1:0] Row_addr,
    output logic                    Frame_done,
    output logic                    Busy
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int BW = (HBLANK > 1) ? $clog2(HBLANK) : 1;
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(HBLANK - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_HBLANK = 2'd3
    } state_t;

    state_t        state, state_n;
    logic          cdq;
    logic          seen_low;
    logic          div_edge;
    logic [BW-1:0] blank_cnt, blank_cnt_n;
    logic [CW-1:0] col_n;
    logic [RW-1:0] row_n;
    logic          lv_n, fs_n, fd_n;

    // seen_low keeps a divider level that is already high at reset release
    // from being taken as a rising edge.
    assign div_edge = CLK_DIV & ~cdq & seen_low;
    assign Busy     = (state != ST_IDLE);

    always_comb begin
        state_n     = state;
        blank_cnt_n = blank_cnt;
        col_n       = Col_addr;
        row_n       = Row_addr;
        lv_n        = Line_valid;
        fs_n        = 1'b0;
        fd_n        = 1'b0;
        case (state)
            ST_IDLE: begin
                col_n       = '0;
                row_n       = '0;
                lv_n        = 1'b0;
                blank_cnt_n = '0;
                if (SYN1 && Enable) state_n = ST_ARMED;
            end
            ST_ARMED: begin
                if (div_edge) begin
                    state_n = ST_ACTIVE;
                    col_n   = '0;
                    row_n   = '0;
                    lv_n    = 1'b1;
                    fs_n    = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (div_edge) begin
                    if (Col_addr == COL_LAST) begin
                        state_n     = ST_HBLANK;
                        lv_n        = 1'b0;
                        col_n       = '0;
                        blank_cnt_n = '0;
                    end else begin
                        col_n = Col_addr + 1'b1;
                    end
                end
            end
            ST_HBLANK: begin
                if (div_edge) begin
                    if (blank_cnt != BLANK_LAST) begin
                        blank_cnt_n = blank_cnt + 1'b1;
                    end else begin
                        blank_cnt_n = '0;
                        if (Row_addr != ROW_LAST) begin
                            row_n   = Row_addr + 1'b1;
                            state_n = ST_ACTIVE;
                            lv_n    = 1'b1;
                        end else begin
                            fd_n  = 1'b1;
                            row_n = '0;
                            if (Enable) begin
                                state_n = ST_ACTIVE;
                                fs_n    = 1'b1;
                                lv_n    = 1'b1;
                            end else begin
                                state_n = ST_IDLE;
                                lv_n    = 1'b0;
                            end
                        end
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // Losing sync-ready overrides any edge processing in the same cycle.
        if (state != ST_IDLE && !SYN1) begin
            state_n     = ST_IDLE;
            blank_cnt_n = '0;
            col_n       = '0;
            row_n       = '0;
            lv_n        = 1'b0;
            fs_n        = 1'b0;
            fd_n        = 1'b0;
        end
    end

    always_ff @(posedge CLKIN) begin
        if (Reset) begin
            state       <= ST_IDLE;
            cdq         <= 1'b0;
            seen_low    <= 1'b0;
            blank_cnt   <= '0;
            Tick        <= 1'b0;
            Frame_start <= 1'b0;
            Frame_done  <= 1'b0;
            Line_valid  <= 1'b0;
            Col_addr    <= '0;
            Row_addr    <= '0;
        end else begin
            state       <= state_n;
            cdq         <= CLK_DIV;
            seen_low    <= seen_low | ~CLK_DIV;
            blank_cnt   <= blank_cnt_n;
            Tick        <= div_edge;
            Frame_start <= fs_n;
            Frame_done  <= fd_n;
            Line_valid  <= lv_n;
            Col_addr    <= col_n;
            Row_addr    <= row_n;
        end
    end
endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: directed scenarios plus random control traffic,
// checked cycle by cycle against a frame-position reference model.
module tb_frame_sequencer;
    localparam int COLS  = 4;
    localparam int ROWS  = 2;
    localparam int HB    = 2;
    localparam int LINE  = COLS + HB;
    localparam int FRAME = ROWS * LINE;
    localparam int DIVP  = 102;

    logic       CLKIN = 1'b0;
    logic       Reset, SYN1, CLK_DIV, Enable;
    logic       Tick, Frame_start, Line_valid, Frame_done, Busy;
    logic [1:0] Col_addr;
    logic [0:0] Row_addr;

    frame_sequencer #(.COLS(COLS), .ROWS(ROWS), .HBLANK(HB)) dut (
        .CLKIN(CLKIN), .Reset(Reset), .SYN1(SYN1), .CLK_DIV(CLK_DIV),
        .Enable(Enable), .Tick(Tick), .Frame_start(Frame_start),
        .Line_valid(Line_valid), .Col_addr(Col_addr), .Row_addr(Row_addr),
        .Frame_done(Frame_done), .Busy(Busy)
    );

    always #5 CLKIN = ~CLKIN;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 idle, 1 armed, 2 running at tick position m_pos
    int m_mode = 0;
    int m_pos  = 0;
    bit m_have_prev = 1'b0;
    bit m_prev = 1'b0;
    int e_tick, e_fs, e_fd, e_lv, e_col, e_row, e_busy;
    int ph = 0;
    int edges = 0;
    int ticks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit e;
        e    = 1'b0;
        e_fs = 0;
        e_fd = 0;
        if (Reset) begin
            m_mode = 0; m_pos = 0; m_have_prev = 1'b0; m_prev = 1'b0;
        end else begin
            e = m_have_prev && !m_prev && (CLK_DIV == 1'b1);
            m_have_prev = 1'b1;
            m_prev = CLK_DIV;
            if (e) edges++;
            if (m_mode != 0 && !SYN1) begin
                m_mode = 0; m_pos = 0;
            end else begin
                case (m_mode)
                    0: if (SYN1 && Enable) m_mode = 1;
                    1: if (e) begin m_mode = 2; m_pos = 0; e_fs = 1; end
                    default: if (e) begin
                        m_pos++;
                        if (m_pos == FRAME) begin
                            e_fd = 1;
                            m_pos = 0;
                            if (Enable) e_fs = 1;
                            else m_mode = 0;
                        end
                    end
                endcase
            end
        end
        e_tick = int'(e);
        if (m_mode == 2) begin
            e_row = m_pos / LINE;
            e_lv  = int'((m_pos % LINE) < COLS);
            e_col = e_lv != 0 ? (m_pos % LINE) : 0;
        end else begin
            e_row = 0; e_lv = 0; e_col = 0;
        end
        e_busy = int'(m_mode != 0);
    endtask

    task automatic cycle();
        CLK_DIV = ((ph % DIVP) >= DIVP / 2);
        ph++;
        @(posedge CLKIN);
        model_step();
        #1;
        if (Tick === 1'b1) ticks++;
        chk("tick",        32'(Tick),        e_tick);
        chk("frame_start", 32'(Frame_start), e_fs);
        chk("frame_done",  32'(Frame_done),  e_fd);
        chk("line_valid",  32'(Line_valid),  e_lv);
        chk("col_addr",    32'(Col_addr),    e_col);
        chk("row_addr",    32'(Row_addr),    e_row);
        chk("busy",        32'(Busy),        e_busy);
    endtask

    function automatic bit next_edge_due();
        return ((ph % DIVP) >= DIVP / 2) && m_have_prev && !m_prev;
    endfunction

    initial begin
        int  n;
        bit  found;
        int  r;
        Reset = 1'b1; SYN1 = 1'b0; Enable = 1'b0; CLK_DIV = 1'b0;
        repeat (4) cycle();
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_lv",   32'(Line_valid), 0);

        // Arm and run the first frame
        Reset = 1'b0; SYN1 = 1'b1; Enable = 1'b1;
        cycle();
        chk("armed_busy", 32'(Busy), 1);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            cycle();
            if (Frame_start === 1'b1) found = 1'b1;
        end
        chk("first_fs_seen", 32'(found), 1);
        chk("first_lv",  32'(Line_valid), 1);
        chk("first_col", 32'(Col_addr), 0);
        chk("first_row", 32'(Row_addr), 0);
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            cycle();
            if (Tick === 1'b1) n++;
            if (Frame_done === 1'b1) found = 1'b1;
        end
        chk("fd_edge_index", n, 12);
        chk("fd_back_to_back_fs", 32'(Frame_start), 1);
        repeat (2 * FRAME * DIVP) cycle();

        // Drop Enable at column 1 of row 0; frame must still complete
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            if (m_mode == 2 && e_col == 1 && e_row == 0 && e_lv == 1) found = 1'b1;
            else cycle();
        end
        chk("en_drop_point", 32'(found), 1);
        Enable = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            cycle();
            if (Frame_done === 1'b1) found = 1'b1;
        end
        chk("en_drop_fd", 32'(found), 1);
        chk("en_drop_busy", 32'(Busy), 0);
        repeat (300) cycle();
        chk("en_drop_idle_busy", 32'(Busy), 0);

        // SYN1 lost in HBLANK on the same cycle as an edge
        Enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            if (m_mode == 2 && (m_pos % LINE) >= COLS && next_edge_due()) found = 1'b1;
            else cycle();
        end
        chk("syn_drop_point", 32'(found), 1);
        SYN1 = 1'b0;
        cycle();
        chk("syn_drop_tick", 32'(Tick), 1);
        chk("syn_drop_busy", 32'(Busy), 0);
        chk("syn_drop_lv",   32'(Line_valid), 0);
        SYN1 = 1'b1;
        repeat (3 * DIVP) cycle();

        // One-cycle reset at row 1 while the divider is high
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            if (m_mode == 2 && e_row == 1 && CLK_DIV === 1'b1 && ((ph % DIVP) >= DIVP / 2)) found = 1'b1;
            else cycle();
        end
        chk("rst_mid_point", 32'(found), 1);
        Reset = 1'b1;
        cycle();
        chk("rst_mid_busy", 32'(Busy), 0);
        chk("rst_mid_row",  32'(Row_addr), 0);
        Reset = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            cycle();
            if (Frame_start === 1'b1) found = 1'b1;
            else if (Tick === 1'b1) found = 1'b1;
        end
        chk("rst_mid_restart", 32'(found), 1);
        chk("rst_mid_fs_after_low", 32'(ph % DIVP), DIVP / 2 + 1);

        // Random control traffic
        for (int i = 0; i < 30000; i++) begin
            if (Reset) Reset = 1'b0;
            r = int'($urandom_range(0, 9999));
            if (r < 3) Reset = 1'b1;
            else if (r < 8) SYN1 = 1'b0;
            else if (r < 30) Enable = ~Enable;
            if (!SYN1 && $urandom_range(0, 199) == 0) SYN1 = 1'b1;
            cycle();
        end

        chk("tick_count", ticks, edges);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
